mul_rr_sched: RTL and testbench

- Round-robin scheduler that shares one iterative shift-add WIDTH x WIDTH unsigned multiply engine between two requesters.
- Each requester presents operands on a valid/ready handshake. The block grants one requester at a time, sequences WIDTH add/shift cycles, then holds the product on a result handshake tagged with the requester id.
- Sits between the operand producers and the shared shift-add multiply datapath; the engine is internal to this block.

---
 rtl/mul_rr_sched_if.sv | 26 ++
 rtl/mul_rr_sched.sv | 71 +++++++
 tb/tb_mul_rr_sched.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/mul_rr_sched_if.sv
// mul_rr_sched_if: request and result handshakes of the shared multiplier.
// master drives operands and takes results; slave is the scheduler.
interface mul_rr_sched_if #(parameter int WIDTH = 8);
    logic                   req0_valid;
    logic                   req0_ready;
    logic [WIDTH-1:0]       req0_a;
    logic [WIDTH-1:0]       req0_b;
    logic                   req1_valid;
    logic                   req1_ready;
    logic [WIDTH-1:0]       req1_a;
    logic [WIDTH-1:0]       req1_b;
    logic                   res_valid;
    logic                   res_ready;
    logic [2*WIDTH-1:0]     res_product;
    logic                   res_id;

    modport master (
        output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
        input  req0_ready, req1_ready, res_valid, res_product, res_id
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, res_ready,
        output req0_ready, req1_ready, res_valid, res_product, res_id
    );
endinterface

// File: rtl/mul_rr_sched.sv
// mul_rr_sched: round-robin sharing of one shift-add multiplier between two requesters.
// Each operation takes WIDTH RUN cycles after accept and is held in DONE until taken.
module mul_rr_sched #(parameter int WIDTH = 8) (
    input  logic          clk,
    input  logic          areset_n,
    mul_rr_sched_if.slave bus,
    output logic          busy
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state, state_nx;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2*WIDTH-1:0] p_q;
    logic [CW-1:0]      cnt;
    logic               id_q, last_grant;
    logic               grant1, take;
    logic [WIDTH:0]     sum;

    // grant, handshake and the carry-kept partial sum of the current step
    always_comb begin
        grant1 = bus.req1_valid && (!bus.req0_valid || !last_grant);
        take   = (state == IDLE) && (bus.req0_valid || bus.req1_valid);
        sum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q[0] ? a_q : '0};
    end

    assign bus.req0_ready  = take && !grant1;
    assign bus.req1_ready  = take && grant1;
    assign bus.res_valid   = state == DONE;
    assign bus.res_product = p_q;
    assign bus.res_id      = id_q;
    assign busy            = state != IDLE;

    // next state: accept -> RUN, WIDTH steps -> DONE, taken -> IDLE
    always_comb begin
        state_nx = state;
        state_nx = (take)                                     ? RUN  :
                   (state == RUN && cnt == CW'(WIDTH - 1))    ? DONE :
                   (state == DONE && bus.res_ready)           ? IDLE : state;
    end

    // state register
    always_ff @(posedge clk) begin
        if (!areset_n) state <= IDLE;
        else           state <= state_nx;
    end

    // operand capture on accept, one shift-add step per RUN cycle
    always_ff @(posedge clk) begin
        if (!areset_n) begin
            a_q        <= '0;
            b_q        <= '0;
            p_q        <= '0;
            cnt        <= '0;
            id_q       <= 1'b0;
            last_grant <= 1'b1;
        end else if (take) begin
            a_q        <= grant1 ? bus.req1_a : bus.req0_a;
            b_q        <= grant1 ? bus.req1_b : bus.req0_b;
            p_q        <= '0;
            cnt        <= '0;
            id_q       <= grant1;
            last_grant <= grant1;
        end else if (state == RUN) begin
            p_q        <= {sum, p_q[WIDTH-1:1]};
            b_q        <= b_q >> 1;
            cnt        <= cnt + CW'(1);
        end
    end
endmodule

// File: tb/tb_mul_rr_sched.sv
// tb_mul_rr_sched: directed and randomized checks of mul_rr_sched against a cycle-count model.
module tb_mul_rr_sched;
    localparam int W = 8;

    logic clk;
    logic areset_n;
    logic busy;
    int   total = 0;
    int   bad = 0;

    mul_rr_sched_if #(.WIDTH(W)) bus ();

    mul_rr_sched #(.WIDTH(W)) dut (
        .clk      (clk),
        .areset_n (areset_n),
        .bus      (bus),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_a = '0;
        bus.req0_b = '0;
        bus.req1_a = '0;
        bus.req1_b = '0;
    endtask

    task automatic do_reset();
        areset_n = 1'b0;
        idle_inputs();
        bus.res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        areset_n = 1'b1;
    endtask

    // one isolated operation on requester id, checking grant, latency and result
    task automatic run_op(input int id, input int a, input int b, input int exp);
        if (id == 0) begin
            bus.req0_valid = 1'b1; bus.req0_a = W'(a); bus.req0_b = W'(b);
        end else begin
            bus.req1_valid = 1'b1; bus.req1_a = W'(a); bus.req1_b = W'(b);
        end
        bus.res_ready = 1'b1;
        #1;
        chk("op_ready0", bus.req0_ready, id == 0);
        chk("op_ready1", bus.req1_ready, id == 1);
        @(negedge clk);
        idle_inputs();
        chk("op_busy", busy, 1);
        chk("op_lat0", bus.res_valid, 0);
        repeat (7) begin
            @(negedge clk);
            chk("op_lat", bus.res_valid, 0);
        end
        @(negedge clk);
        chk("op_valid", bus.res_valid, 1);
        chk("op_product", bus.res_product, exp);
        chk("op_id", bus.res_id, id);
        @(negedge clk);
        chk("op_drop", bus.res_valid, 0);
        chk("op_idle", busy, 0);
    endtask

    // randomized-phase model: one outstanding op with a cycle timer, per-requester FIFOs
    bit          m_idle, m_done, m_last, m_id;
    int          m_timer;
    int unsigned q0[$], q1[$];

    initial begin
        int ops, cyc, rate0, rate1, win;
        logic v0, v1, rr;
        logic [W-1:0] a0, b0, a1, b1;
        logic [31:0] e;

        do_reset();
        chk("rst_valid", bus.res_valid, 0);
        chk("rst_product", bus.res_product, 0);
        chk("rst_id", bus.res_id, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready0", bus.req0_ready, 0);
        chk("rst_ready1", bus.req1_ready, 0);

        run_op(0, 13, 11, 143);
        run_op(1, 255, 255, 32'hFE01);
        run_op(1, 0, 200, 0);

        // contention from reset: 0 then 1 then 0
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_a = 3; bus.req0_b = 5;
        bus.req1_valid = 1'b1; bus.req1_a = 7; bus.req1_b = 9;
        #1;
        chk("rr_first0", bus.req0_ready, 1);
        chk("rr_first1", bus.req1_ready, 0);
        repeat (9) @(negedge clk);
        chk("rr_res1", bus.res_product, 15);
        chk("rr_id1", bus.res_id, 0);
        @(negedge clk);
        chk("rr_second0", bus.req0_ready, 0);
        chk("rr_second1", bus.req1_ready, 1);
        repeat (9) @(negedge clk);
        chk("rr_res2", bus.res_product, 63);
        chk("rr_id2", bus.res_id, 1);
        @(negedge clk);
        chk("rr_third0", bus.req0_ready, 1);
        chk("rr_third1", bus.req1_ready, 0);
        @(negedge clk);
        idle_inputs();
        repeat (8) @(negedge clk);
        chk("rr_res3", bus.res_product, 15);
        chk("rr_id3", bus.res_id, 0);
        @(negedge clk);

        // backpressure: result held for 5 cycles with both requesters waiting
        bus.res_ready = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = 4; bus.req0_b = 6;
        @(negedge clk);
        idle_inputs();
        repeat (8) @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_valid", bus.res_valid, 1);
            chk("bp_product", bus.res_product, 24);
            chk("bp_id", bus.res_id, 0);
            chk("bp_ready0", bus.req0_ready, 0);
            chk("bp_ready1", bus.req1_ready, 0);
        end
        bus.res_ready = 1'b1;
        #1;
        chk("bp_take_ready0", bus.req0_ready, 0);
        chk("bp_take_ready1", bus.req1_ready, 0);
        @(negedge clk);
        chk("bp_after_valid", bus.res_valid, 0);
        chk("bp_after_busy", busy, 0);
        chk("bp_after_ready1", bus.req1_ready, 1);
        chk("bp_after_ready0", bus.req0_ready, 0);
        idle_inputs();

        // reset in the middle of RUN discards the operation
        do_reset();
        bus.req0_valid = 1'b1; bus.req0_a = 200; bus.req0_b = 100;
        @(negedge clk);
        idle_inputs();
        repeat (3) @(negedge clk);
        areset_n = 1'b0;
        @(negedge clk);
        areset_n = 1'b1;
        chk("mr_busy", busy, 0);
        chk("mr_valid", bus.res_valid, 0);
        chk("mr_product", bus.res_product, 0);
        repeat (10) begin
            @(negedge clk);
            chk("mr_no_result", bus.res_valid, 0);
        end
        run_op(0, 6, 7, 42);

        // randomized traffic against the model
        do_reset();
        m_idle = 1; m_done = 0; m_last = 1; m_id = 0; m_timer = 0;
        ops = 0; cyc = 0; rate0 = 50; rate1 = 50;
        while (ops < 500 && cyc < 40000) begin
            if (cyc % 400 == 0) begin
                rate0 = $urandom_range(10, 95);
                rate1 = $urandom_range(10, 95);
            end
            chk("rnd_valid", bus.res_valid, m_done);
            chk("rnd_busy", busy, !m_idle);
            if (m_done) begin
                e = m_id ? (q1.size() > 0 ? q1[0] : 'x) : (q0.size() > 0 ? q0[0] : 'x);
                chk("rnd_product", bus.res_product, e);
                chk("rnd_id", bus.res_id, m_id);
            end
            v0 = $urandom_range(99) < rate0;
            v1 = $urandom_range(99) < rate1;
            a0 = W'($urandom); b0 = W'($urandom);
            a1 = W'($urandom); b1 = W'($urandom);
            rr = $urandom_range(99) < 70;
            bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0;
            bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1;
            bus.res_ready = rr;
            #1;
            win = -1;
            if (m_idle && (v0 || v1)) win = (v0 && v1) ? (m_last ? 0 : 1) : (v1 ? 1 : 0);
            chk("rnd_ready0", bus.req0_ready, win == 0);
            chk("rnd_ready1", bus.req1_ready, win == 1);
            if (win >= 0) begin
                if (win == 0) q0.push_back(int'(a0) * int'(b0));
                else          q1.push_back(int'(a1) * int'(b1));
                m_idle = 0; m_timer = W; m_last = win[0]; m_id = win[0];
            end else if (m_timer > 0) begin
                m_timer--;
                if (m_timer == 0) m_done = 1;
            end else if (m_done && rr) begin
                m_done = 0; m_idle = 1;
                if (m_id) void'(q1.pop_front());
                else      void'(q0.pop_front());
                ops++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("rnd_ops", ops, 500);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
